// File: rtl/debug_unit_pkg.sv
// Shared constants for the host debug unit: command codes, halt word,
// default address width and the controller state encoding.
package debug_unit_pkg;

    localparam int ADDRWIDTH = 8;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD_BYTE  = 4'd1;
    localparam logic [3:0] S_LOAD_WRITE = 4'd2;
    localparam logic [3:0] S_RUN        = 4'd3;
    localparam logic [3:0] S_STEP       = 4'd4;
    localparam logic [3:0] S_DUMP_SETUP = 4'd5;
    localparam logic [3:0] S_DUMP_WAIT  = 4'd6;
    localparam logic [3:0] S_DUMP_SEND  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

endpackage

// File: rtl/debug_word_tx.sv
// Serialises one 32-bit word into 4 UART bytes, MSB first.
// Ports: i_word/i_load in, o_tx_data/o_tx_start to UART tx,
// i_tx_done from UART tx, o_word_done 1-cycle when word is finished.
module debug_word_tx (
    input  logic        clock,
    input  logic        i_reset,
    input  logic [31:0] i_word,
    input  logic        i_load,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    output logic        o_word_done
);

    logic [23:0] rest_q;
    logic [1:0]  idx_q;
    logic        busy_q;
    logic        start_q;
    logic        done_q;
    logic [7:0]  data_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rest_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (!busy_q) begin
                // a stray tx_done while idle falls through here
                if (i_load) begin
                    busy_q  <= 1'b1;
                    idx_q   <= '0;
                    data_q  <= i_word[31:24];
                    rest_q  <= i_word[23:0];
                    start_q <= 1'b1;
                end
            end else if (i_tx_done && !start_q) begin
                if (idx_q == 2'd3) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    idx_q   <= idx_q + 2'd1;
                    data_q  <= rest_q[23:16];
                    rest_q  <= {rest_q[15:0], 8'h00};
                    start_q <= 1'b1;
                end
            end
        end
    end

    assign o_tx_data   = data_q;
    assign o_tx_start  = start_q;
    assign o_word_done = done_q;

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: UART program load, run/step gating, state dump.
// Ports: UART rx/tx bytes, imem write port, pipe enable, regfile/dmem
// debug read ports. Option DEBUG_UNIT_CYCLE_COUNT_EN adds a cycle count word.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = ADDRWIDTH,
    parameter int NB_REG      = 5,
    parameter int N_REGISTER  = 32,
    parameter int N_MEM_WORDS = 16,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_im_data,
    output logic [NB_ADDR-1:0] o_im_addr,
    output logic               o_im_write,
    output logic               o_enable_pipe,
    output logic               o_debug_unit,
    output logic [NB_REG-1:0]  o_br_addr,
    output logic               o_br_enable,
    output logic [NB_ADDR-1:0] o_dm_addr,
    output logic               o_dm_enable
);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int N_HDR = 2;
`else
    localparam int N_HDR = 1;
`endif
    localparam int N_ITEMS = N_HDR + N_REGISTER + N_MEM_WORDS;
    localparam int NB_ITEM = $clog2(N_ITEMS + 1);

    logic [3:0]          state_q;
    logic [NB_DATA-9:0]  ld_word_q;
    logic [1:0]          ld_cnt_q;
    logic [NB_ADDR-1:0]  im_addr_q;
    logic [NB_DATA-1:0]  im_data_q;
    logic                im_write_q;
    logic [NB_ITEM-1:0]  item_q;
    logic                wait_q;
    logic                wl_q;
    logic [31:0]         wd_q;
    logic [NB_REG-1:0]   br_addr_q;
    logic                br_en_q;
    logic [NB_ADDR-1:0]  dm_addr_q;
    logic                dm_en_q;
    logic                word_done;
    logic                enable_pipe;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    logic [31:0]         cc_q;
`endif

    // Enable falls in the very cycle halt is seen, not one later.
    always_comb begin
        enable_pipe = ((state_q == S_RUN) && !i_halt)
                    || (state_q == S_STEP);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            ld_word_q  <= '0;
            ld_cnt_q   <= '0;
            im_addr_q  <= '0;
            im_data_q  <= '0;
            im_write_q <= 1'b0;
            item_q     <= '0;
            wait_q     <= 1'b0;
            wl_q       <= 1'b0;
            wd_q       <= '0;
            br_addr_q  <= '0;
            br_en_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_en_q    <= 1'b0;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
            cc_q       <= '0;
`endif
        end else begin
            wl_q <= 1'b0;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
            if (enable_pipe) cc_q <= cc_q + 32'd1;
`endif
            case (state_q)
                S_IDLE: begin
                    item_q <= '0;
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_LOAD) begin
                            ld_cnt_q <= '0;
                            state_q  <= S_LOAD_BYTE;
                        end else if (i_rx_data == CMD_CONT) begin
                            state_q <= S_RUN;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
                            cc_q    <= '0;
`endif
                        end else if (i_rx_data == CMD_STEP) begin
                            state_q <= S_STEP;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
                            cc_q    <= '0;
`endif
                        end
                    end
                end
                S_LOAD_BYTE: begin
                    if (i_rx_done) begin
                        ld_cnt_q <= ld_cnt_q + 2'd1;
                        if (ld_cnt_q == 2'd3) begin
                            im_data_q  <= {ld_word_q, i_rx_data};
                            im_write_q <= 1'b1;
                            state_q    <= S_LOAD_WRITE;
                        end else begin
                            ld_word_q <= {ld_word_q[NB_DATA-17:0],
                                          i_rx_data};
                        end
                    end
                end
                S_LOAD_WRITE: begin
                    im_write_q <= 1'b0;
                    im_addr_q  <= im_addr_q + 1'b1;
                    if (im_data_q == HALT_WORD
                        || im_addr_q == {NB_ADDR{1'b1}})
                        state_q <= S_IDLE;
                    else
                        state_q <= S_LOAD_BYTE;
                end
                S_RUN: begin
                    if (i_halt) state_q <= S_DUMP_SETUP;
                end
                S_STEP: begin
                    state_q <= S_DUMP_SETUP;
                end
                S_DUMP_SETUP: begin
                    wait_q <= 1'b0;
                    if (item_q == '0) begin
                        wl_q    <= 1'b1;
                        wd_q    <= 32'(i_pc);
                        state_q <= S_DUMP_SEND;
                    end
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
                    else if (item_q == NB_ITEM'(1)) begin
                        wl_q    <= 1'b1;
                        wd_q    <= cc_q;
                        state_q <= S_DUMP_SEND;
                    end
`endif
                    else if (item_q < NB_ITEM'(N_HDR + N_REGISTER)) begin
                        br_addr_q <= NB_REG'(item_q - NB_ITEM'(N_HDR));
                        br_en_q   <= 1'b1;
                        dm_en_q   <= 1'b0;
                        state_q   <= S_DUMP_WAIT;
                    end else begin
                        dm_addr_q <= NB_ADDR'(item_q
                                     - NB_ITEM'(N_HDR + N_REGISTER));
                        dm_en_q   <= 1'b1;
                        br_en_q   <= 1'b0;
                        state_q   <= S_DUMP_WAIT;
                    end
                end
                S_DUMP_WAIT: begin
                    // read data is taken two cycles after the address
                    if (wait_q) begin
                        wl_q    <= 1'b1;
                        wd_q    <= br_en_q ? 32'(i_reg_data)
                                           : 32'(i_mem_data);
                        state_q <= S_DUMP_SEND;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                S_DUMP_SEND: begin
                    if (word_done) begin
                        if (item_q == NB_ITEM'(N_ITEMS - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            item_q  <= item_q + 1'b1;
                            state_q <= S_DUMP_SETUP;
                        end
                    end
                end
                S_DONE: begin
                    br_en_q <= 1'b0;
                    dm_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    debug_word_tx u_word_tx (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_word      (wd_q),
        .i_load      (wl_q),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_word_done (word_done)
    );

    assign o_im_data     = im_data_q;
    assign o_im_addr     = im_addr_q;
    assign o_im_write    = im_write_q;
    assign o_enable_pipe = enable_pipe;
    assign o_debug_unit  = (state_q == S_LOAD_BYTE)
                        || (state_q == S_LOAD_WRITE)
                        || (state_q == S_DUMP_SETUP)
                        || (state_q == S_DUMP_WAIT)
                        || (state_q == S_DUMP_SEND)
                        || (state_q == S_DONE);
    assign o_br_addr     = br_addr_q;
    assign o_br_enable   = br_en_q;
    assign o_dm_addr     = dm_addr_q;
    assign o_dm_enable   = dm_en_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed-plus-random bench for debug_unit with a byte-stream
// reference model, UART transmitter model and regfile/dmem models.
module tb_debug_unit;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int OFF = 4;
`else
    localparam int OFF = 0;
`endif
    localparam int DUMP_LEN = 4 * (1 + 32 + 16) + OFF;

    logic        clock = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done;
    logic        i_halt;
    logic [7:0]  i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [31:0] o_im_data;
    logic [7:0]  o_im_addr;
    logic        o_im_write;
    logic        o_enable_pipe;
    logic        o_debug_unit;
    logic [4:0]  o_br_addr;
    logic        o_br_enable;
    logic [7:0]  o_dm_addr;
    logic        o_dm_enable;

    always #5 clock = ~clock;

    debug_unit dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_tx_done     (i_tx_done),
        .i_halt        (i_halt),
        .i_pc          (i_pc),
        .i_reg_data    (i_reg_data),
        .i_mem_data    (i_mem_data),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_im_data     (o_im_data),
        .o_im_addr     (o_im_addr),
        .o_im_write    (o_im_write),
        .o_enable_pipe (o_enable_pipe),
        .o_debug_unit  (o_debug_unit),
        .o_br_addr     (o_br_addr),
        .o_br_enable   (o_br_enable),
        .o_dm_addr     (o_dm_addr),
        .o_dm_enable   (o_dm_enable)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] regs [32];
    logic [31:0] mems [256];
    logic [7:0]  txq  [$];
    logic [7:0]  expq [$];
    logic [7:0]  wa   [$];
    logic [31:0] wdat [$];
    int          en_cnt  = 0;
    int          hs_viol = 0;
    bit          tx_busy = 0;
    int          tx_delay = 0;

    // register file and data memory: one-cycle registered reads
    always @(posedge clock) begin
        i_reg_data <= regs[o_br_addr];
        i_mem_data <= mems[o_dm_addr];
    end

    always @(negedge clock) begin
        if (o_tx_start) begin
            if (tx_busy) hs_viol++;
            txq.push_back(o_tx_data);
            tx_busy  = 1;
            tx_delay = $urandom_range(0, 3);
        end
        if (o_im_write) begin
            wa.push_back(o_im_addr);
            wdat.push_back(o_im_data);
        end
        if (o_enable_pipe) en_cnt++;
    end

    // transmitter: finishes each byte a few cycles after its start
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            i_tx_done = 1'b0;
            if (tx_busy) begin
                if (tx_delay == 0) begin
                    i_tx_done = 1'b1;
                    tx_busy   = 0;
                end else begin
                    tx_delay--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8]);
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic randomize_state();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 256; i++) mems[i] = $urandom;
    endtask

    // expected dump: list of words, each split MSB first
    task automatic build_exp(input logic [7:0] pc, input logic [31:0] cc);
        logic [31:0] w [$];
        w.push_back({24'h0, pc});
        if (OFF != 0) w.push_back(cc);
        for (int i = 0; i < 32; i++) w.push_back(regs[i]);
        for (int i = 0; i < 16; i++) w.push_back(mems[i]);
        expq.delete();
        foreach (w[i])
            for (int k = 3; k >= 0; k--) expq.push_back(w[i][8*k +: 8]);
    endtask

    task automatic wait_dump(input string tag);
        int t = 0;
        int bad = 0;
        while (!(txq.size() >= expq.size() && !o_debug_unit && !tx_busy)
               && t < 6000) begin
            tick();
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 6000), 32'd1);
        chk({tag, "_len"}, 32'(txq.size()), 32'(expq.size()));
        foreach (expq[i])
            if (i >= txq.size() || txq[i] !== expq[i]) bad++;
        chk({tag, "_bytes_bad"}, 32'(bad), 32'd0);
        chk({tag, "_handshake"}, 32'(hs_viol), 32'd0);
    endtask

    initial begin
        logic [31:0] rw [3];
        int          t;
        int          nw;
        i_reset   = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_halt    = 1'b0;
        i_pc      = 8'h00;
        randomize_state();
        repeat (3) tick();

        chk("rst_tx_start", 32'(o_tx_start), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_im_write", 32'(o_im_write), 32'd0);
        chk("rst_im_addr", 32'(o_im_addr), 32'd0);
        chk("rst_enable", 32'(o_enable_pipe), 32'd0);
        chk("rst_debug", 32'(o_debug_unit), 32'd0);
        chk("rst_br_en", 32'(o_br_enable), 32'd0);
        chk("rst_dm_en", 32'(o_dm_enable), 32'd0);
        i_reset = 1'b1;
        tick();

        // directed load
        send_byte(8'h4C);
        tick();
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        tick();
        chk("load_n", 32'(wa.size()), 32'd2);
        chk("load_a0", 32'(wa[0]), 32'd0);
        chk("load_d0", wdat[0], 32'h0000_0001);
        chk("load_a1", 32'(wa[1]), 32'd1);
        chk("load_d1", wdat[1], 32'hFFFF_FFFF);
        chk("load_idle", 32'(o_debug_unit), 32'd0);
        chk("load_ctr", 32'(o_im_addr), 32'd2);

        // random load continues from the counter
        for (int i = 0; i < 3; i++) begin
            rw[i] = $urandom;
            if (rw[i] == 32'hFFFF_FFFF) rw[i] = 32'h1234_5678;
        end
        send_byte(8'h4C);
        tick();
        for (int i = 0; i < 3; i++) send_word(rw[i]);
        send_word(32'hFFFF_FFFF);
        tick();
        chk("rload_n", 32'(wa.size()), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk("rload_addr", 32'(wa[2+i]), 32'(2 + i));
            chk("rload_data", wdat[2+i], rw[i]);
        end
        chk("rload_ctr", 32'(o_im_addr), 32'd6);

        // garbage byte in IDLE
        send_byte(8'h41);
        repeat (5) tick();
        chk("garb_debug", 32'(o_debug_unit), 32'd0);
        chk("garb_enable", 32'(en_cnt), 32'd0);
        chk("garb_tx", 32'(txq.size()), 32'd0);
        chk("garb_im", 32'(wa.size()), 32'd6);

        // run with halt after 10 cycles, stray 'L' ignored
        randomize_state();
        i_pc = 8'($urandom);
        build_exp(i_pc, 32'd10);
        txq.delete();
        en_cnt = 0;
        send_byte(8'h43);
        for (int i = 0; i < 10; i++) begin
            i_rx_data = 8'h4C;
            i_rx_done = (i == 3);
            tick();
        end
        i_rx_done = 1'b0;
        i_halt    = 1'b1;
        tick();
        i_halt = 1'b0;
        wait_dump("run");
        chk("run_enable_cycles", 32'(en_cnt), 32'd10);
        chk("run_no_load", 32'(wa.size()), 32'd6);
        if (OFF != 0)
            chk("run_cc", {txq[4], txq[5], txq[6], txq[7]}, 32'd10);

        // single step
        randomize_state();
        regs[3] = 32'hDEAD_BEEF;
        i_pc = 8'h04;
        build_exp(i_pc, 32'd1);
        txq.delete();
        en_cnt = 0;
        send_byte(8'h53);
        wait_dump("step");
        chk("step_enable", 32'(en_cnt), 32'd1);
        chk("step_pc", {txq[0], txq[1], txq[2], txq[3]}, 32'h4);
        chk("step_r3", {txq[16+OFF], txq[17+OFF], txq[18+OFF],
                        txq[19+OFF]}, 32'hDEAD_BEEF);

        // step while already halted
        randomize_state();
        i_pc = 8'($urandom);
        build_exp(i_pc, 32'd1);
        txq.delete();
        en_cnt = 0;
        i_halt = 1'b1;
        send_byte(8'h53);
        wait_dump("hstep");
        i_halt = 1'b0;
        chk("hstep_enable", 32'(en_cnt), 32'd1);

        // reset in the middle of a dump
        txq.delete();
        send_byte(8'h53);
        t = 0;
        while (txq.size() < 50 && t < 4000) begin
            tick();
            t++;
        end
        chk("abort_reach50", 32'(t < 4000), 32'd1);
        i_reset = 1'b0;
        #1;
        chk("abort_tx_start", 32'(o_tx_start), 32'd0);
        chk("abort_tx_data", 32'(o_tx_data), 32'd0);
        chk("abort_debug", 32'(o_debug_unit), 32'd0);
        chk("abort_br_en", 32'(o_br_enable), 32'd0);
        chk("abort_dm_en", 32'(o_dm_enable), 32'd0);
        chk("abort_im_addr", 32'(o_im_addr), 32'd0);
        tx_busy = 0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        tick();
        txq.delete();
        nw = 0;
        randomize_state();
        i_pc = 8'($urandom);
        build_exp(i_pc, 32'd1);
        send_byte(8'h53);
        wait_dump("fresh");
        chk("fresh_len196", 32'(txq.size()), 32'(DUMP_LEN));
        chk("fresh_nw", 32'(nw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
